// File: rtl/uart_tx_fifo_arbiter_if.sv
// Client and FIFO-write signals of the UART TX FIFO arbiter.
// slave = arbiter side, master = clients plus FIFO side.
interface uart_tx_fifo_arbiter_if #(
  parameter int B = 8
);
  logic         req0;
  logic [B-1:0] data0;
  logic         last0;
  logic         ack0;
  logic         req1;
  logic [B-1:0] data1;
  logic         last1;
  logic         ack1;
  logic         fifo_full;
  logic         fifo_wr;
  logic [B-1:0] fifo_w_data;
  logic [1:0]   owner;

  modport slave (
    input  req0, data0, last0, req1, data1, last1, fifo_full,
    output ack0, ack1, fifo_wr, fifo_w_data, owner
  );

  modport master (
    output req0, data0, last0, req1, data1, last1, fifo_full,
    input  ack0, ack1, fifo_wr, fifo_w_data, owner
  );
endinterface

// File: rtl/uart_tx_fifo_arbiter.sv
// Burst-granular round-robin arbiter for the UART TX FIFO write port; zero-latency
// handshake (ack/wr combinational from owner state), stalls on fifo_full.
module uart_tx_fifo_arbiter #(
  parameter int B         = 8,
  parameter int MAX_BURST = 16,
  parameter int IDLE_TMO  = 8
) (
  input logic                  clk,
  input logic                  reset,
  uart_tx_fifo_arbiter_if.slave bus
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TMO + 1);

  // State code doubles as the owner output encoding.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          last_owner_q, last_owner_d;

  logic          cur_req;
  logic          cur_last;
  logic [B-1:0]  cur_data;
  logic          owning;
  logic          accept;
  logic          release_burst;

  always_comb begin
    cur_req  = 1'b0;
    cur_last = 1'b0;
    cur_data = '0;
    case (state_q)
      OWN0: begin
        cur_req  = bus.req0;
        cur_last = bus.last0;
        cur_data = bus.data0;
      end
      OWN1: begin
        cur_req  = bus.req1;
        cur_last = bus.last1;
        cur_data = bus.data1;
      end
      default: ;
    endcase
  end

  assign owning = (state_q == OWN0) || (state_q == OWN1);
  assign accept = owning && cur_req && !bus.fifo_full;

  // A full-stalled byte keeps req high, so it neither releases nor counts as idle.
  assign release_burst = owning &&
                         ((accept && cur_last) ||
                          (accept && (burst_cnt_q == BW'(MAX_BURST - 1))) ||
                          (!cur_req && (idle_cnt_q == IW'(IDLE_TMO - 1))));

  assign bus.fifo_wr     = accept;
  assign bus.fifo_w_data = cur_data;
  assign bus.ack0        = accept && (state_q == OWN0);
  assign bus.ack1        = accept && (state_q == OWN1);
  assign bus.owner       = state_q;

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    last_owner_d = last_owner_q;
    if (!owning) begin
      burst_cnt_d = '0;
      idle_cnt_d  = '0;
      if (bus.req0 && bus.req1) begin
        state_d = last_owner_q ? OWN0 : OWN1;
      end else if (bus.req0) begin
        state_d = OWN0;
      end else if (bus.req1) begin
        state_d = OWN1;
      end
    end else if (release_burst) begin
      state_d      = IDLE;
      last_owner_d = (state_q == OWN1);
      burst_cnt_d  = '0;
      idle_cnt_d   = '0;
    end else begin
      if (accept) begin
        burst_cnt_d = burst_cnt_q + BW'(1);
      end
      idle_cnt_d = cur_req ? '0 : idle_cnt_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      idle_cnt_q   <= '0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

endmodule
